// File: rtl/cdc_hs_pkg.sv
// Shared types and defaults for the toggle-handshake source block and its synchronizer.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 255;

  // A disabled (0) or single-cycle timeout still needs a one-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer with async active-low reset to 0.
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle req/ack word handshake from clk_a into clk_b,
// with a sticky timeout flag for a receiver that never answers.
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk_a,
  input  logic              arstn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  input  logic              rx_ack,
  output logic              done,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output state_t            dbg_state
);

  // Handshake: a word moves when s_valid && s_ready are both high at a rising
  // clk_a edge; s_valid without s_ready is ignored and s_data may change freely.

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic             ack_s;
  logic             in_phase;
  logic [CNT_W-1:0] cnt;

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk_a),
    .arstn (arstn),
    .d     (rx_ack),
    .q     (ack_s)
  );

  assign in_phase  = (ack_s == tx_req);
  assign s_ready   = (state == IDLE) && in_phase;
  assign dbg_state = state;

  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state   <= IDLE;
      tx_data <= '0;
      tx_req  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      // A timeout landing in the same cycle as err_clr wins (assigned later).
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid && in_phase) begin
            tx_data <= s_data;
            tx_req  <= ~tx_req;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= WAIT;
          end else if (!in_phase) begin
            busy  <= 1'b1;
            state <= RESYNC;
          end
        end
        WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          if (TIMEOUT != 0 && cnt == CNT_LAST) err <= 1'b1;
          if (in_phase) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RESYNC: begin
          // Receiver ack was out of phase after a one-sided reset; no done.
          if (in_phase) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed scenarios plus randomized transfers
// checked against a cycle-offset model and a received-word queue.
module tb_cdc_handshake_tx;
  import cdc_hs_pkg::*;

  localparam int DW = 4;
  localparam int SS = 2;
  localparam int TO = 8;

  logic          clk_a = 1'b0;
  logic          arstn = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          rx_ack = 1'b0;
  logic          err_clr = 1'b0;
  logic          s_ready, tx_req, done, busy, err;
  logic [DW-1:0] tx_data;
  state_t        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic model_req = 1'b0;
  logic model_err = 1'b0;

  always #5 clk_a = ~clk_a;
  always @(posedge clk_a) cyc <= cyc + 1;

  cdc_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk_a(clk_a), .arstn(arstn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tx_data(tx_data), .tx_req(tx_req), .rx_ack(rx_ack),
    .done(done), .busy(busy), .err(err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Resets block and receiver together; leaves the bench at a negedge.
  task automatic apply_reset();
    arstn = 1'b0; s_valid = 1'b0; err_clr = 1'b0; rx_ack = 1'b0;
    exp_q.delete(); model_req = 1'b0; model_err = 1'b0;
    @(negedge clk_a); @(negedge clk_a);
    arstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_a); @(negedge clk_a);
    n_cmp++; if (tx_data !== '0) begin n_err++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    n_cmp++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    n_cmp++; if ({done, busy, err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: done/busy/err got %b want 000", {done, busy, err}); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    arstn = 1'b1;
    @(negedge clk_a);
    n_cmp++; if ({s_ready, busy} !== 2'b10) begin n_err++; $display("FAIL post_reset_idle: ready/busy got %b want 10", {s_ready, busy}); end
  endtask

  // One word; receiver toggles rx_ack just before edge d after the accept edge.
  // noise: 0 quiet, 1 random s_valid while busy, 2 s_valid held high while busy.
  task automatic do_transfer(input logic [DW-1:0] w, input int d, input int noise);
    logic [DW-1:0] exp_w;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL xfer_ready_pre: got %b want 1", s_ready); end
    s_data = w; s_valid = 1'b1;
    exp_q.push_back(w); model_req = ~model_req;
    for (int i = 0; i <= d + SS; i++) begin
      @(negedge clk_a);
      n_cmp++; if (tx_data !== w) begin n_err++; $display("FAIL xfer_data i=%0d: got %h want %h", i, tx_data, w); end
      n_cmp++; if (tx_req !== model_req) begin n_err++; $display("FAIL xfer_req i=%0d: got %b want %b", i, tx_req, model_req); end
      n_cmp++; if (done !== (i == d + SS)) begin n_err++; $display("FAIL xfer_done i=%0d: got %b want %b", i, done, (i == d + SS)); end
      n_cmp++; if (s_ready !== (i >= d + SS)) begin n_err++; $display("FAIL xfer_ready i=%0d: got %b want %b", i, s_ready, (i >= d + SS)); end
      n_cmp++; if (busy !== (i < d + SS)) begin n_err++; $display("FAIL xfer_busy i=%0d: got %b want %b", i, busy, (i < d + SS)); end
      n_cmp++; if (err !== model_err) begin n_err++; $display("FAIL xfer_err i=%0d: got %b want %b", i, err, model_err); end
      if (i == d - 1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rx_underflow: receiver saw data with nothing queued");
        end else begin
          exp_w = exp_q.pop_front();
          n_cmp++; if (tx_data !== exp_w) begin n_err++; $display("FAIL rx_word: got %h want %h", tx_data, exp_w); end
        end
        rx_ack = ~rx_ack;
      end
      s_data  = DW'($urandom);
      s_valid = 1'b0;
      if (i < d + SS) begin
        if (noise == 1) s_valid = 1'($urandom_range(0, 1));
        if (noise == 2) s_valid = 1'b1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    do_transfer(4'hA, 4, 0);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [3];
    int acc_cyc [3];
    int n_acc, n_done;
    logic prev_req;
    logic [DW-1:0] exp_w;
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
    n_acc = 0; n_done = 0;
    apply_reset();
    prev_req = 1'b0;
    s_data = words[0]; s_valid = 1'b1;
    for (int t = 0; t < 40 && !(n_acc == 3 && n_done == 3); t++) begin
      @(negedge clk_a);
      if (done === 1'b1) n_done++;
      if (tx_req !== prev_req && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        exp_q.push_back(words[n_acc]); model_req = ~model_req;
        n_cmp++; if (tx_req !== model_req) begin n_err++; $display("FAIL b2b_req #%0d: got %b want %b", n_acc, tx_req, model_req); end
        n_cmp++; if (tx_data !== words[n_acc]) begin n_err++; $display("FAIL b2b_data #%0d: got %h want %h", n_acc, tx_data, words[n_acc]); end
        if (n_acc > 0) begin
          n_cmp++; if (acc_cyc[n_acc] - acc_cyc[n_acc-1] != SS + 2) begin n_err++; $display("FAIL b2b_spacing #%0d: got %0d want %0d", n_acc, acc_cyc[n_acc] - acc_cyc[n_acc-1], SS + 2); end
        end
        prev_req = tx_req; n_acc++;
        if (n_acc < 3) s_data = words[n_acc];
        else s_valid = 1'b0;
      end
      // Immediate receiver: answers as soon as it sees the request toggle.
      if (tx_req !== rx_ack && exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        n_cmp++; if (tx_data !== exp_w) begin n_err++; $display("FAIL b2b_rx_word: got %h want %h", tx_data, exp_w); end
        rx_ack = tx_req;
      end
    end
    s_valid = 1'b0;
    n_cmp++; if (n_acc != 3) begin n_err++; $display("FAIL b2b_accepts: got %0d want 3", n_acc); end
    n_cmp++; if (n_done != 3) begin n_err++; $display("FAIL b2b_dones: got %0d want 3", n_done); end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] exp_w;
    apply_reset();
    s_data = 4'hC; s_valid = 1'b1;
    exp_q.push_back(4'hC); model_req = ~model_req;
    for (int i = 0; i <= 15; i++) begin
      @(negedge clk_a);
      s_valid = 1'b0; s_data = DW'($urandom);
      n_cmp++; if (tx_data !== 4'hC) begin n_err++; $display("FAIL to_data i=%0d: got %h want c", i, tx_data); end
      n_cmp++; if (tx_req !== model_req) begin n_err++; $display("FAIL to_req i=%0d: got %b want %b", i, tx_req, model_req); end
      n_cmp++; if (err !== (i >= TO)) begin n_err++; $display("FAIL to_err i=%0d: got %b want %b", i, err, (i >= TO)); end
      n_cmp++; if (done !== (i == 15)) begin n_err++; $display("FAIL to_done i=%0d: got %b want %b", i, done, (i == 15)); end
      n_cmp++; if (busy !== (i < 15)) begin n_err++; $display("FAIL to_busy i=%0d: got %b want %b", i, busy, (i < 15)); end
      // err_clr overlaps the edge on which the timeout fires.
      err_clr = (i == TO - 2) || (i == TO - 1);
      if (i == 12) begin
        exp_w = exp_q.pop_front();
        n_cmp++; if (tx_data !== exp_w) begin n_err++; $display("FAIL to_rx_word: got %h want %h", tx_data, exp_w); end
        rx_ack = ~rx_ack;
      end
    end
    err_clr = 1'b1;
    @(negedge clk_a);
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL to_err_clr: got %b want 0", err); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL to_done_drop: got %b want 0", done); end
  endtask

  task automatic test_resync();
    apply_reset();
    rx_ack = 1'b1;  // receiver kept its old ack across our reset
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_a);
      n_cmp++; if (busy !== (i >= 3 && i <= 6)) begin n_err++; $display("FAIL rs_busy i=%0d: got %b want %b", i, busy, (i >= 3 && i <= 6)); end
      n_cmp++; if (s_ready !== (i <= 1 || i >= 7)) begin n_err++; $display("FAIL rs_ready i=%0d: got %b want %b", i, s_ready, (i <= 1 || i >= 7)); end
      n_cmp++; if ({done, tx_req} !== 2'b00) begin n_err++; $display("FAIL rs_quiet i=%0d: done/req got %b want 00", i, {done, tx_req}); end
      if (i == 4) rx_ack = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    s_data = 4'h7; s_valid = 1'b1;
    @(negedge clk_a);
    s_valid = 1'b0;
    @(negedge clk_a);
    n_cmp++; if ({busy, tx_req} !== 2'b11) begin n_err++; $display("FAIL mid_wait: busy/req got %b want 11", {busy, tx_req}); end
    #1 arstn = 1'b0;
    #1;
    n_cmp++; if ({tx_data, tx_req, done, busy, err} !== '0) begin n_err++; $display("FAIL mid_async_reset: data/req/done/busy/err got %h want 0", {tx_data, tx_req, done, busy, err}); end
    exp_q.delete(); model_req = 1'b0; model_err = 1'b0;
    @(negedge clk_a);
    arstn = 1'b1;
    do_transfer(4'h5, 2, 0);
  endtask

  task automatic test_busy_ignore();
    apply_reset();
    do_transfer(4'h9, 4, 2);
    @(negedge clk_a);
    n_cmp++; if ({tx_data, tx_req} !== {4'h9, 1'b1}) begin n_err++; $display("FAIL ignore_after: data/req got %h want 13", {tx_data, tx_req}); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      do_transfer(DW'($urandom), $urandom_range(1, 4), 1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk_a);
        n_cmp++; if ({s_ready, done, busy} !== 3'b100) begin n_err++; $display("FAIL rnd_gap: ready/done/busy got %b want 100", {s_ready, done, busy}); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_queue: %0d words left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_resync();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source side of the toggle-based four-phase-free request/acknowledge handshake used to move a multi-bit word from the clk_a domain into the clk_b domain. Accepts a word over a valid/ready interface, holds it stable on tx_data, signals a new word by toggling tx_req, and waits for the clk_b receiver to toggle rx_ack before the next word is accepted. The returning acknowledge is synchronized internally. A timeout monitor flags a receiver that never answers.

## Interface
- DATA_W, 4: width of transferred word
- SYNC_STAGES, 2: flops in rx_ack synchronizer, legal 2..4
- TIMEOUT, 255: clk_a cycles in WAIT before err sets; 0 disables monitor
- Reset arstn, asynchronous, active-low; clock clk_a.
- clk_a  in  1  source-domain clock
- arstn  in  1  async active-low reset
- s_data  in  DATA_W  word to transfer
- s_valid  in  1  s_data valid
- s_ready  out  1  block can accept a word
- tx_data  out  DATA_W  registered word held stable toward clk_b domain
- tx_req  out  1  registered request toggle toward clk_b domain
- rx_ack  in  1  acknowledge toggle from clk_b domain (asynchronous)
- done  out  1  one-cycle pulse: receiver acknowledged current word
- busy  out  1  transfer outstanding (state != IDLE)
- err  out  1  sticky timeout flag
- err_clr  in  1  synchronous clear of err

## Operation
- ack_s = rx_ack after SYNC_STAGES flops; only ack_s is used internally.
- States: IDLE, WAIT, RESYNC.
- IDLE: s_ready = (ack_s == tx_req). On s_valid && s_ready: tx_data <= s_data, tx_req <= ~tx_req, go WAIT. If ack_s != tx_req in IDLE, go RESYNC (s_ready low).
- WAIT: when ack_s == tx_req: done pulses, go IDLE. tx_data, tx_req never change in WAIT.
- RESYNC: entered only after one-sided reset (receiver ack out of phase). Stays until ack_s == tx_req, then IDLE; no done pulse.
- Timeout counter: clears on entry to WAIT, increments per WAIT cycle, saturates at TIMEOUT. When it reaches TIMEOUT (TIMEOUT != 0) err sets. Transfer is not aborted; block keeps waiting. err_clr clears err; err_clr and new timeout in same cycle -> err stays set.
- s_valid without s_ready is ignored; s_data need not stay stable.
- Reset values: tx_data 0, tx_req 0, done 0, busy 0, err 0, state IDLE, synchronizer flops 0, counter 0. s_ready 1 after reset only if rx_ack settles 0 through synchronizer (it does from reset value 0).
- Reset mid-transfer: word lost, outputs return to reset values; if receiver was not reset and its ack is 1, block sits in RESYNC until receiver realigns.

## Timing
- Accept sampled at edge E0; tx_data/tx_req updated at E0; busy high, s_ready low from E0.
- rx_ack toggle before edge E1 -> ack_s changes at E(SYNC_STAGES); state returns IDLE and done high at E(SYNC_STAGES+1); s_ready high same cycle as done.
- Minimum accept-to-accept: SYNC_STAGES+2 clk_a cycles with immediate receiver.
- Back-to-back: s_valid held high accepts next word in the done cycle.
- tx_data stable at least from tx_req toggle until ack_s matches; receiver may sample tx_data any time after synchronizing tx_req.

## Structure
- Package cdc_hs_pkg: state typedef (IDLE, WAIT, RESYNC), default DATA_W/SYNC_STAGES/TIMEOUT constants.
- Sub-module cdc_sync_bit (SYNC_STAGES parameter, async active-low reset to 0) instantiated for rx_ack; reused by the clk_b receiver for tx_req.
- Counter width $clog2(TIMEOUT+1), minimum 1.

## Test plan
- Reset, then s_data=4'hA, s_valid=1; bench toggles rx_ack 3 cycles later -> tx_data=4'hA, tx_req=1 at E0; done at E6; s_ready low E0..E5.
- Back-to-back 4'h1,4'h2,4'h3 with immediate-ack model -> tx_req toggles 1,0,1; accept spacing exactly 4 cycles; three done pulses.
- rx_ack never toggles, TIMEOUT=8 -> err sets 8 cycles after entering WAIT; tx_data held; late ack still yields done; err_clr then clears err.
- Drive rx_ack=1 after reset (receiver not reset) -> RESYNC, s_ready=0; drop rx_ack to 0 -> IDLE two cycles later, no done.
- Assert arstn low during WAIT -> all outputs zero immediately; after release, new word 4'h5 transfers normally.
- s_valid pulses while busy -> ignored; tx_data unchanged, no extra tx_req toggle.
